// File: rtl/read_ecc_decode_if.sv
// rtl/read_ecc_decode_if.sv - capture/result handshake bundle for read_ecc_decode
//
// Purpose: groups the codeword-pair capture handshake and the decoded-result
// handshake of read_ecc_decode into one bundle.
// Signals:
//   in_valid, in_ready              capture handshake (pair offered / decoder idle)
//   in_add[7:0]                     read address of the pair
//   in_data_A/in_data_B[11:0]       Hamming(12,8) codewords from the two data disks
//   out_valid, out_ready            result handshake
//   out_add[7:0], out_data[15:0]    address and {byte_A, byte_B}
//   out_corr[1:0], out_uncorr[1:0]  per-disk flags, [1]=A, [0]=B
// Modports:
//   master  upstream/downstream side (drives the pair and out_ready)
//   slave   the decoder

interface read_ecc_decode_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_add;
    logic [11:0] in_data_A;
    logic [11:0] in_data_B;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_add;
    logic [15:0] out_data;
    logic [1:0]  out_corr;
    logic [1:0]  out_uncorr;

    modport master (
        output in_valid, in_add, in_data_A, in_data_B, out_ready,
        input  in_ready, out_valid, out_add, out_data, out_corr, out_uncorr
    );

    modport slave (
        input  in_valid, in_add, in_data_A, in_data_B, out_ready,
        output in_ready, out_valid, out_add, out_data, out_corr, out_uncorr
    );
endinterface

// File: rtl/read_ecc_decode.sv
// rtl/read_ecc_decode.sv - dual Hamming(12,8) read-path decoder with event counters
//
// Purpose: captures a pair of Hamming(12,8) codewords plus their read address,
// corrects single-bit errors, flags uncorrectable syndromes and presents the
// two data bytes on a held result handshake. Keeps saturating correction and
// uncorrectable event counters and a sticky flag for pairs offered while busy.
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high
//   bus         read_ecc_decode_if.slave (capture and result handshakes)
//   cnt_clr     clears corr_cnt, uncorr_cnt and overflow; wins over same-edge updates
//   corr_cnt    saturating count of corrected codewords
//   uncorr_cnt  saturating count of uncorrectable codewords
//   overflow    sticky: a pair was offered while the decoder was not idle

module read_ecc_decode (
    input  logic               clk,
    input  logic               reset,
    read_ecc_decode_if.slave   bus,
    input  logic               cnt_clr,
    output logic [7:0]         corr_cnt,
    output logic [7:0]         uncorr_cnt,
    output logic               overflow
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    // DECODE spans two cycles: phase 0 registers the syndromes, phase 1
    // applies the correction and loads the result registers. This puts
    // out_valid two edges after the capture edge.
    logic        dec_phase;

    logic [7:0]  cap_add;
    logic [11:0] cap_a;
    logic [11:0] cap_b;
    logic [3:0]  syn_a;
    logic [3:0]  syn_b;

    logic [7:0]  res_add;
    logic [15:0] res_data;
    logic [1:0]  res_corr;
    logic [1:0]  res_uncorr;

    logic [7:0]  byte_a;
    logic [7:0]  byte_b;
    logic [1:0]  dec_corr;
    logic [1:0]  dec_uncorr;
    logic        decode_done;

    // Codeword bit k carries Hamming position k+1, so the syndrome is the
    // XOR of (k+1) over every set bit.
    function automatic logic [3:0] syndrome(input logic [11:0] cw);
        logic [3:0] s;
        s = 4'd0;
        for (int k = 0; k < 12; k++) begin
            if (cw[k]) begin
                s = s ^ 4'(k + 1);
            end
        end
        return s;
    endfunction

    // Syndromes 1..12 name the failing position (parity bits included);
    // 13..15 point outside the word and are left untouched.
    function automatic logic [11:0] correct(input logic [11:0] cw, input logic [3:0] s);
        logic [11:0] fixed;
        fixed = cw;
        if (s != 4'd0 && s <= 4'd12) begin
            fixed = cw ^ (12'd1 << (s - 4'd1));
        end
        return fixed;
    endfunction

    // Data d7..d0 live at positions 12,11,10,9,7,6,5,3.
    function automatic logic [7:0] extract(input logic [11:0] cw);
        return {cw[11], cw[10], cw[9], cw[8], cw[6], cw[5], cw[4], cw[2]};
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] cnt, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {7'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[1]} + {1'b0, v[0]};
    endfunction

    always_comb begin
        byte_a     = extract(correct(cap_a, syn_a));
        byte_b     = extract(correct(cap_b, syn_b));
        dec_corr   = {(syn_a != 4'd0) && (syn_a <= 4'd12),
                      (syn_b != 4'd0) && (syn_b <= 4'd12)};
        dec_uncorr = {syn_a > 4'd12, syn_b > 4'd12};
    end

    assign decode_done = (state == DECODE) && dec_phase;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_next = DECODE;
                end
            end
            DECODE: begin
                if (dec_phase) begin
                    state_next = OUTPUT;
                end
            end
            OUTPUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture, syndrome and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_phase  <= 1'b0;
            cap_add    <= 8'd0;
            cap_a      <= 12'd0;
            cap_b      <= 12'd0;
            syn_a      <= 4'd0;
            syn_b      <= 4'd0;
            res_add    <= 8'd0;
            res_data   <= 16'd0;
            res_corr   <= 2'd0;
            res_uncorr <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    dec_phase <= 1'b0;
                    if (bus.in_valid) begin
                        cap_add <= bus.in_add;
                        cap_a   <= bus.in_data_A;
                        cap_b   <= bus.in_data_B;
                    end
                end
                DECODE: begin
                    if (!dec_phase) begin
                        syn_a     <= syndrome(cap_a);
                        syn_b     <= syndrome(cap_b);
                        dec_phase <= 1'b1;
                    end else begin
                        res_add    <= cap_add;
                        res_data   <= {byte_a, byte_b};
                        res_corr   <= dec_corr;
                        res_uncorr <= dec_uncorr;
                        dec_phase  <= 1'b0;
                    end
                end
                default: begin
                    dec_phase <= 1'b0;
                end
            endcase
        end
    end

    // Event counters and the dropped-input flag; clear beats any update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            corr_cnt   <= 8'd0;
            uncorr_cnt <= 8'd0;
            overflow   <= 1'b0;
        end else if (cnt_clr) begin
            corr_cnt   <= 8'd0;
            uncorr_cnt <= 8'd0;
            overflow   <= 1'b0;
        end else begin
            if (decode_done) begin
                corr_cnt   <= sat_add(corr_cnt, popcount2(dec_corr));
                uncorr_cnt <= sat_add(uncorr_cnt, popcount2(dec_uncorr));
            end
            if (bus.in_valid && state != IDLE) begin
                overflow <= 1'b1;
            end
        end
    end

    assign bus.out_add    = res_add;
    assign bus.out_data   = res_data;
    assign bus.out_corr   = res_corr;
    assign bus.out_uncorr = res_uncorr;

endmodule

// File: tb/tb_read_ecc_decode.sv
// tb/tb_read_ecc_decode.sv - randomized self-checking bench for read_ecc_decode

module tb_read_ecc_decode;

    logic       clk = 1'b0;
    logic       reset;
    logic       cnt_clr;
    logic [7:0] corr_cnt;
    logic [7:0] uncorr_cnt;
    logic       overflow;

    read_ecc_decode_if bus();

    read_ecc_decode dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .cnt_clr    (cnt_clr),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   exp_corr = 0;
    int   exp_uncorr = 0;
    logic exp_ovf  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: positions 1..12, data at the non-power-of-two positions.
    function automatic logic [3:0] ref_syn(input logic [11:0] cw);
        int s = 0;
        for (int p = 1; p <= 12; p++) begin
            if (cw[p-1]) s = s ^ p;
        end
        return 4'(s);
    endfunction

    task automatic ref_decode(input logic [11:0] cw, output logic [7:0] b,
                              output logic c, output logic u);
        int          dpos [8] = '{3, 5, 6, 7, 9, 10, 11, 12};
        logic [3:0]  s;
        logic [11:0] fixed;
        s     = ref_syn(cw);
        fixed = cw;
        c     = 1'b0;
        u     = 1'b0;
        if (s >= 1 && s <= 12) begin
            fixed[s-1] = ~fixed[s-1];
            c = 1'b1;
        end else if (s > 12) begin
            u = 1'b1;
        end
        for (int i = 0; i < 8; i++) b[i] = fixed[dpos[i]-1];
    endtask

    function automatic logic [11:0] encode(input logic [7:0] d);
        int          dpos [8] = '{3, 5, 6, 7, 9, 10, 11, 12};
        logic [11:0] cw = 12'd0;
        logic [3:0]  s;
        for (int i = 0; i < 8; i++) cw[dpos[i]-1] = d[i];
        s = ref_syn(cw);
        for (int j = 0; j < 4; j++) if (s[j]) cw[(1 << j) - 1] = 1'b1;
        return cw;
    endfunction

    function automatic logic [11:0] single_err(input logic [7:0] d);
        logic [11:0] cw = encode(d);
        int          k  = int'($urandom_range(0, 11));
        cw[k] = ~cw[k];
        return cw;
    endfunction

    function automatic logic [11:0] rand_cw();
        int mode = int'($urandom_range(0, 2));
        if (mode == 0) return encode(8'($urandom));
        if (mode == 1) return single_err(8'($urandom));
        return 12'($urandom);
    endfunction

    task automatic check_counters(input string tag);
        check({tag, "_corr_cnt"},   corr_cnt,   exp_corr);
        check({tag, "_uncorr_cnt"}, uncorr_cnt, exp_uncorr);
        check({tag, "_overflow"},   overflow,   exp_ovf);
    endtask

    // Offers a pair, checks the two-edge latency, the result, the counters,
    // holds the result for 'hold' cycles and completes the handshake.
    // With busy_pulse, in_valid is offered while busy and again in the
    // handshake cycle; neither may be accepted.
    task automatic do_txn(input logic [7:0] add, input logic [11:0] a, input logic [11:0] b,
                          input int hold, input bit busy_pulse);
        logic [7:0] ba, bb;
        logic       ca, ua, cb, ub;
        ref_decode(a, ba, ca, ua);
        ref_decode(b, bb, cb, ub);
        exp_corr   = (exp_corr + ca + cb > 255) ? 255 : exp_corr + ca + cb;
        exp_uncorr = (exp_uncorr + ua + ub > 255) ? 255 : exp_uncorr + ua + ub;

        @(negedge clk);
        check("in_ready_idle", bus.in_ready, 1'b1);
        bus.in_valid  = 1'b1;
        bus.in_add    = add;
        bus.in_data_A = a;
        bus.in_data_B = b;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("lat_e0_valid", bus.out_valid, 1'b0);
        check("lat_e0_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        check("lat_e1_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        check("lat_e2_valid", bus.out_valid, 1'b1);
        check("out_data",   bus.out_data,   {ba, bb});
        check("out_add",    bus.out_add,    add);
        check("out_corr",   bus.out_corr,   {ca, cb});
        check("out_uncorr", bus.out_uncorr, {ua, ub});
        check_counters("txn");

        for (int i = 0; i < hold; i++) begin
            bus.in_valid = busy_pulse && (i == 0);
            if (busy_pulse && i == 0) begin
                bus.in_add    = 8'hEE;
                bus.in_data_A = 12'hABC;
                bus.in_data_B = 12'h123;
                exp_ovf       = 1'b1;
            end
            @(negedge clk);
            check("hold_valid", bus.out_valid, 1'b1);
            check("hold_data",  bus.out_data,  {ba, bb});
            check("hold_add",   bus.out_add,   add);
            check("hold_flags", {bus.out_corr, bus.out_uncorr}, {ca, cb, ua, ub});
        end

        bus.out_ready = 1'b1;
        bus.in_valid  = busy_pulse;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("hs_valid_low", bus.out_valid, 1'b0);
        check("hs_in_ready",  bus.in_ready,  1'b1);
        if (busy_pulse) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check("hs_not_taken", {bus.in_ready, bus.out_valid}, 2'b10);
            end
            check_counters("busy");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        cnt_clr       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_add    = 8'd0;
        bus.in_data_A = 12'd0;
        bus.in_data_B = 12'd0;
        bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_in_ready",  bus.in_ready,  1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data",  bus.out_data,  16'd0);
        check("rst_out_add",   bus.out_add,   8'd0);
        check("rst_flags",     {bus.out_corr, bus.out_uncorr}, 4'd0);
        check_counters("rst");
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_valid", bus.out_valid, 1'b0);

        // Directed pairs: clean, single error on B, uncorrectable A.
        do_txn(8'h21, 12'hF77, 12'h000, 0, 1'b0);
        do_txn(8'h42, 12'h000, 12'hF67, 1, 1'b0);
        do_txn(8'h63, 12'h089, 12'h000, 0, 1'b0);

        // Backpressure with a pair offered while busy and at the handshake.
        do_txn(8'h7A, encode(8'h5A), single_err(8'hC3), 5, 1'b1);

        for (int n = 0; n < 40; n++) begin
            do_txn(8'($urandom), rand_cw(), rand_cw(), int'($urandom_range(0, 2)), 1'b0);
        end

        // Both codewords single-error: +2 per pair, saturating at 255.
        for (int n = 0; n < 130; n++) begin
            do_txn(8'(n), single_err(8'($urandom)), single_err(8'($urandom)), 0, 1'b0);
        end
        check("sat_corr_cnt", corr_cnt, 8'd255);

        // Clear concurrent with a counter increment and an overflow set.
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_add    = 8'h99;
        bus.in_data_A = single_err(8'h11);
        bus.in_data_B = single_err(8'h22);
        @(posedge clk);
        #1 cnt_clr = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        exp_corr   = 0;
        exp_uncorr = 0;
        exp_ovf    = 1'b0;
        @(negedge clk);
        check("clr_valid",   bus.out_valid, 1'b1);
        check("clr_corr",    bus.out_corr,  2'b11);
        check_counters("clr");
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;

        // Reset while a result is being presented.
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_add    = 8'h5C;
        bus.in_data_A = single_err(8'h77);
        bus.in_data_B = 12'h089;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_valid", bus.out_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_valid",    bus.out_valid, 1'b0);
        check("mid_rst_in_ready", bus.in_ready,  1'b1);
        check("mid_rst_data",     bus.out_data,  16'd0);
        check("mid_rst_add",      bus.out_add,   8'd0);
        check("mid_rst_flags",    {bus.out_corr, bus.out_uncorr}, 4'd0);
        exp_corr   = 0;
        exp_uncorr = 0;
        exp_ovf    = 1'b0;
        check_counters("mid_rst");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("after_rst_quiet", {bus.in_ready, bus.out_valid}, 2'b10);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/read_ecc_decode.md
READ_ECC_DECODE -- requirements
Module: read_ecc_decode

Interface
REQ-001 SHALL have clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have reset  input  1  asynchronous, active-high; clock clk.
REQ-003 SHALL have in_valid  input  1  codeword pair valid from the normal-read stage (its out_mem_valid).
REQ-004 SHALL have in_add  input  8  read address of the pair.
REQ-005 SHALL have in_data_A / in_data_B  input  12 each  Hamming(12,8) codewords from the two data disks.
REQ-006 SHALL have in_ready  output  1  high when able to capture a pair.
REQ-007 SHALL have out_valid  output  1 / out_ready  input  1  result handshake.
REQ-008 SHALL have out_add  output  8, out_data  output  16  ({byte_A, byte_B}), out_corr  output  2, out_uncorr  output  2  ([1]=A, [0]=B).
REQ-009 SHALL have corr_cnt / uncorr_cnt  output  8 each  saturating event counters; cnt_clr  input  1  counter/flag clear; overflow  output  1  sticky dropped-input flag.

Function
REQ-010 Codeword bit k SHALL hold Hamming position k+1; parity at positions 1,2,4,8; data d0..d7 at positions 3,5,6,7,9,10,11,12 (bits 2,4,5,6,8,9,10,11).
REQ-011 Syndrome SHALL be the 4-bit XOR of the position numbers of all set bits.
REQ-012 Syndrome 0: no error; byte extracted unchanged; corr=0, uncorr=0.
REQ-013 Syndrome 1..12: flip bit (syndrome-1) before extraction; corr=1 (including parity-only errors).
REQ-014 Syndrome 13..15: no flip; byte extracted raw; uncorr=1, corr=0.
REQ-015 FSM states: IDLE, DECODE, OUTPUT.
  - IDLE: in_ready=1; in_valid=1 at edge -> capture in_add, in_data_A, in_data_B; go DECODE.
  - DECODE: compute both syndromes, register out_data/out_corr/out_uncorr/out_add; go OUTPUT.
  - OUTPUT: out_valid=1; all out_* held stable until out_valid&&out_ready at an edge -> IDLE.
REQ-016 Latency SHALL be: capture edge N, out_valid high from after edge N+2.
REQ-017 in_ready SHALL be 0 in DECODE and OUTPUT; in_valid there SHALL be dropped and SHALL set overflow.
REQ-018 In IDLE, in_valid in the same cycle as the preceding OUTPUT->IDLE handshake SHALL NOT be accepted (capture only when already in IDLE).
REQ-019 On DECODE->OUTPUT, corr_cnt SHALL add popcount(out_corr) and uncorr_cnt popcount(out_uncorr), each saturating at 255.
REQ-020 cnt_clr SHALL zero corr_cnt, uncorr_cnt, overflow at the edge, taking priority over a same-cycle increment or overflow set.
REQ-021 out_valid SHALL be 0 outside OUTPUT; out_data/out_add/flags SHALL retain their last value outside OUTPUT.

Reset
REQ-022 Reset SHALL force IDLE, in_ready=1, out_valid=0, out_data=0, out_add=0, out_corr=0, out_uncorr=0, corr_cnt=0, uncorr_cnt=0, overflow=0, capture registers 0.
REQ-023 Reset mid-DECODE or mid-OUTPUT SHALL discard the pending result; no out_valid pulse after release without a new in_valid.

Verification
REQ-024 Clean: A=0xF77, B=0x000, add=0x21 -> out_data=0xFF00, out_add=0x21, corr=00, uncorr=00, out_valid 2 cycles after capture.
REQ-025 Single error: A=0x000, B=0xF67 (0xF77 with bit4 flipped) -> out_data=0x00FF, out_corr=01, corr_cnt +1.
REQ-026 Uncorrectable: A=0x089 (syndrome 13), B=0x000 -> out_uncorr=10, out_corr=00, out_data=0x0000, uncorr_cnt +1.
REQ-027 Backpressure: out_ready=0 for 5 cycles, in_valid pulsed during OUTPUT -> outputs stable, pulse dropped, overflow=1; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-028 Saturation/clear: 130 pairs each with both codewords single-error -> corr_cnt=255; cnt_clr with concurrent increment -> corr_cnt=0, overflow=0.
REQ-029 Reset asserted while in OUTPUT -> out_valid=0 immediately, all outputs at reset values, in_ready=1.
